// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and interrupt/mret sequencer for the RV32 core.
// Optional feature macro: MCYCLE_EN adds a 64-bit mcycle counter at 0xB00/0xB80.
// Reads are combinational and return the pre-write value. Writes commit at the
// clock edge of a retiring instruction. Trap entry and mret drive a PC redirect.
module csr_trap_unit #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [2:0]      funct3,
  input  logic            csr_wre,
  input  logic            csr_rde,
  input  logic            is_mret,
  input  logic [XLEN-1:0] pc_next_in,
  input  logic            instr_retire,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_taken,
  output logic            illegal_csr
);

  localparam logic [XLEN-1:0] MCAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

  // Architectural state
  logic                   mie_q, mie_d;       // mstatus.MIE
  logic                   mpie_q, mpie_d;     // mstatus.MPIE
  logic                   meie_q, meie_d;     // mie.MEIE
  logic [XLEN-1:2]        mtvec_q, mtvec_d;
  logic [XLEN-1:0]        mscratch_q, mscratch_d;
  logic [XLEN-1:2]        mepc_q, mepc_d;
  logic [XLEN-1:0]        mcause_q, mcause_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
`ifdef MCYCLE_EN
  logic [2*XLEN-1:0]      mcycle_q, mcycle_d;
`endif

  logic            meip_s;
  logic            mret_s;
  logic            irq_take_s;
  logic            sel_hit_s;
  logic [XLEN-1:0] sel_val_s;
  logic [XLEN-1:0] wval_s;
  logic            op_valid_s;
  logic            wr_en_s;
  logic [XLEN-1:0] mstatus_s;
  logic [XLEN-1:0] mie_s;
  logic [XLEN-1:0] mip_s;
  logic            unused_funct3_s;

  // funct3[2] only selects rs1 vs zimm, which the datapath has already resolved.
  assign unused_funct3_s = funct3[2];

  // Synchroniser: ext_irq is a raw asynchronous level from the UART.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq};
  assign meip_s = sync_q[SYNC_STAGES-1];

  // Read-view composition of the sparse status registers
  always_comb begin
    mstatus_s     = {XLEN{1'b0}};
    mstatus_s[3]  = mie_q;
    mstatus_s[7]  = mpie_q;
    mie_s         = {XLEN{1'b0}};
    mie_s[11]     = meie_q;
    mip_s         = {XLEN{1'b0}};
    mip_s[11]     = meip_s;
  end

  assign mret_s     = is_mret & instr_retire;
  // mret defers a pending interrupt to the next retiring instruction.
  assign irq_take_s = mie_q & meie_q & meip_s & instr_retire & ~is_mret;

  // Address decode: selected CSR value and whether the address is implemented
  always_comb begin
    sel_hit_s = 1'b1;
    sel_val_s = {XLEN{1'b0}};
    case (csr_addr)
      12'h300: sel_val_s = mstatus_s;
      12'h304: sel_val_s = mie_s;
      12'h305: sel_val_s = {mtvec_q, 2'b00};
      12'h340: sel_val_s = mscratch_q;
      12'h341: sel_val_s = {mepc_q, 2'b00};
      12'h342: sel_val_s = mcause_q;
      12'h344: sel_val_s = mip_s;
`ifdef MCYCLE_EN
      12'hB00: sel_val_s = mcycle_q[XLEN-1:0];
      12'hB80: sel_val_s = mcycle_q[2*XLEN-1:XLEN];
`endif
      default: sel_hit_s = 1'b0;
    endcase
  end

  // Read-modify-write value for the CSR op
  always_comb begin
    op_valid_s = 1'b1;
    wval_s     = sel_val_s;
    case (funct3[1:0])
      2'b01:   wval_s = csr_wdata;
      2'b10:   wval_s = sel_val_s | csr_wdata;
      2'b11:   wval_s = sel_val_s & ~csr_wdata;
      default: op_valid_s = 1'b0;
    endcase
  end

  assign wr_en_s = csr_wre & instr_retire & sel_hit_s & op_valid_s;

  // Combinational outputs; reset forces them inactive immediately
  always_comb begin
    csr_rdata      = {XLEN{1'b0}};
    redirect_valid = 1'b0;
    redirect_pc    = {XLEN{1'b0}};
    trap_taken     = 1'b0;
    illegal_csr    = 1'b0;
    if (!rst) begin
      csr_rdata      = (csr_rde && sel_hit_s) ? sel_val_s : {XLEN{1'b0}};
      illegal_csr    = (csr_rde | csr_wre) & ~sel_hit_s;
      trap_taken     = irq_take_s;
      redirect_valid = irq_take_s | mret_s;
      if (irq_take_s) begin
        redirect_pc = {mtvec_q, 2'b00};
      end else if (mret_s) begin
        redirect_pc = {mepc_q, 2'b00};
      end else begin
        redirect_pc = {XLEN{1'b0}};
      end
    end else begin
      csr_rdata = {XLEN{1'b0}};
    end
  end

  // Next-state: software writes first, then trap entry / mret override mstatus/mepc/mcause
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef MCYCLE_EN
    mcycle_d   = mcycle_q + {{(2*XLEN-1){1'b0}}, 1'b1};
`endif
    if (wr_en_s) begin
      case (csr_addr)
        12'h300: begin
          mie_d  = wval_s[3];
          mpie_d = wval_s[7];
        end
        12'h304: meie_d     = wval_s[11];
        12'h305: mtvec_d    = wval_s[XLEN-1:2];
        12'h340: mscratch_d = wval_s;
        12'h341: mepc_d     = wval_s[XLEN-1:2];
        12'h342: mcause_d   = wval_s;
`ifdef MCYCLE_EN
        12'hB00: mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], wval_s};
        12'hB80: mcycle_d   = {wval_s, mcycle_q[XLEN-1:0]};
`endif
        default: mcause_d   = mcause_q;  // mip is read-only
      endcase
    end else begin
      mcause_d = mcause_q;
    end
    if (irq_take_s) begin
      mepc_d   = pc_next_in[XLEN-1:2];
      mcause_d = MCAUSE_MEI;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_s) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
    end else begin
      mepc_d   = mepc_d;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= {(XLEN-2){1'b0}};
      mscratch_q <= {XLEN{1'b0}};
      mepc_q     <= {(XLEN-2){1'b0}};
      mcause_q   <= {XLEN{1'b0}};
      sync_q     <= {SYNC_STAGES{1'b0}};
`ifdef MCYCLE_EN
      mcycle_q   <= {(2*XLEN){1'b0}};
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      sync_q     <= sync_d;
`ifdef MCYCLE_EN
      mcycle_q   <= mcycle_d;
`endif
    end
  end

endmodule
